// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states and arithmetic helpers for the systolic array
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [64:0] sat_add(input logic signed [64:0] acc,
                                                 input logic signed [64:0] p,
                                                 input int acc_w, input logic sat,
                                                 output logic ovf);
    logic signed [64:0] s, hi, lo, wr;
    s = acc + p;
    hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    wr = (s <<< (65 - acc_w)) >>> (65 - acc_w);
    ovf = (s > hi) || (s < lo);
    return !ovf ? s : !sat ? wr : (s > hi) ? hi : lo;
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary MAC cell with operand forwarding
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int W = 8,
  parameter int ACC_W = 24,
  parameter bit SAT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     w_i,
  input  logic                    v_i,
  output logic signed [W-1:0]     a_o,
  output logic signed [W-1:0]     w_o,
  output logic                    v_o,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    ovf_o
);
  logic signed [W-1:0] a_q, w_q;
  logic v_q, ovf_q, hit;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [2*W-1:0] prod;
  logic signed [64:0] sum;
  always_comb begin
    prod = a_i * w_i;
    sum = sat_add(65'(acc_q), 65'(prod), ACC_W, SAT, hit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      w_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_i;
      w_q <= w_i;
      v_q <= v_i;
    end
    if (rst || clr_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (v_i) begin
      acc_q <= ACC_W'(sum);
      ovf_q <= ovf_q | hit;
    end
  end
  assign a_o = a_q;
  assign w_o = w_q;
  assign v_o = v_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/systolic_os_array.sv
// systolic_os_array: output-stationary ROWS x COLS MAC array with skewed loading and row-wise drain
module systolic_os_array
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W = 8,
  parameter int ACC_W = 24,
  parameter int K_W = 8,
  parameter bit SAT = 1'b1,
  localparam int RW = idx_w(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [K_W-1:0]        k_len_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ROWS*W-1:0]     a_vec_i,
  input  logic [COLS*W-1:0]     w_vec_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [COLS*ACC_W-1:0] out_data_o,
  output logic [RW-1:0]         out_row_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o
);
  localparam int CNT_W = K_W > 16 ? K_W : 16;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic done_q, take, clr;
  logic signed [W-1:0] a_h [ROWS][COLS+1];
  logic v_h [ROWS][COLS+1];
  logic signed [W-1:0] w_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc [ROWS][COLS];
  logic [ROWS*COLS-1:0] pe_ovf;
  assign take = state_q == LOAD && in_valid_i;
  assign clr = state_q == IDLE && start_i;
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [W-1:0] sr_q [r+1];
    logic vs_q [r+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          sr_q[i] <= '0;
          vs_q[i] <= 1'b0;
        end
      end else begin
        sr_q[0] <= take ? a_vec_i[r*W +: W] : '0;
        vs_q[0] <= take;
        for (int i = 1; i <= r; i++) begin
          sr_q[i] <= sr_q[i-1];
          vs_q[i] <= vs_q[i-1];
        end
      end
    end
    assign a_h[r][0] = sr_q[r];
    assign v_h[r][0] = vs_q[r];
  end
  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    logic signed [W-1:0] sw_q [c+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) sw_q[i] <= '0;
      end else begin
        sw_q[0] <= take ? w_vec_i[c*W +: W] : '0;
        for (int i = 1; i <= c; i++) sw_q[i] <= sw_q[i-1];
      end
    end
    assign w_v[0][c] = sw_q[c];
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      systolic_pe #(.W(W), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
        .clk(clk), .rst(rst), .clr_i(clr),
        .a_i(a_h[r][c]), .w_i(w_v[r][c]), .v_i(v_h[r][c]),
        .a_o(a_h[r][c+1]), .w_o(w_v[r+1][c]), .v_o(v_h[r][c+1]),
        .acc_o(acc[r][c]), .ovf_o(pe_ovf[r*COLS+c])
      );
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = k_len_i == '0 ? DRAIN : LOAD;
        cnt_d = CNT_W'(k_len_i);
        row_d = '0;
      end
      LOAD: if (in_valid_i) begin
        state_d = cnt_q == CNT_W'(1) ? FLUSH : LOAD;
        cnt_d = cnt_q == CNT_W'(1) ? CNT_W'(ROWS + COLS - 1) : cnt_q - 1'b1;
      end
      FLUSH: begin
        state_d = cnt_q == CNT_W'(1) ? DRAIN : FLUSH;
        cnt_d = cnt_q - 1'b1;
      end
      DRAIN: if (out_ready_i) begin
        state_d = out_last_o ? IDLE : DRAIN;
        row_d = out_last_o ? '0 : row_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      done_q <= state_q == DRAIN && out_ready_i && out_last_o;
    end
  end
  always_comb begin
    out_data_o = '0;
    for (int c = 0; c < COLS; c++) out_data_o[c*ACC_W +: ACC_W] = acc[row_q][c];
  end
  assign in_ready_o = state_q == LOAD;
  assign out_valid_o = state_q == DRAIN;
  assign busy_o = state_q != IDLE;
  assign out_row_o = row_q;
  assign out_last_o = row_q == RW'(ROWS - 1);
  assign done_o = done_q;
  assign ovf_o = |pe_ovf;
endmodule
